// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm
// Control sequencer for the parametrised processor datapath. Fetches an
// instruction (T0), decodes it from the IR contents (T1), and walks the
// datapath through operand load, ALU or memory phases. LD/ST talk to memory
// through a req/ack handshake that gives up after MEM_TIMEOUT cycles.
// All datapath controls are decoded combinationally from state + IR.

module proc_ctrl_fsm #(
  parameter int  DATA_W      = 16,
  parameter int  NUM_REGS    = 8,
  parameter int  MEM_TIMEOUT = 15,
  localparam int RI          = $clog2(NUM_REGS),
  localparam int SEL_W       = $clog2(NUM_REGS + 3)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [DATA_W-1:0]   ir_out,
  input  logic                mem_ack,
  output logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] rx_in,
  output logic                ir_in,
  output logic                a_in,
  output logic                g_in,
  output logic                addr_in,
  output logic                dout_in,
  output logic [1:0]          alu_op,
  output logic                imm_hi,
  output logic                mem_req,
  output logic                mem_wr,
  output logic                done,
  output logic                err,
  output logic                halted
);

  // Wide enough to hold 0..MEM_TIMEOUT-1 for any MEM_TIMEOUT >= 1.
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  // Bus mux codes for the non-register sources.
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(NUM_REGS + 1);
  localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(NUM_REGS + 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_MEM  = 3'd5,
    S_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVT  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_AND  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ------------------------------------------------------------------
  // Instruction field decode
  // ------------------------------------------------------------------
  op_t              op;
  logic             imm;
  logic [RI-1:0]    rx_idx;
  logic [RI-1:0]    ry_idx;
  logic [SEL_W-1:0] rx_sel;
  logic [SEL_W-1:0] src_sel;
  logic [NUM_REGS-1:0] rx_onehot;
  logic [1:0]       alu_code;

  assign op      = op_t'(ir_out[DATA_W-1 -: 3]);
  assign imm     = ir_out[DATA_W-4];
  assign rx_idx  = ir_out[DATA_W-5 -: RI];
  assign ry_idx  = ir_out[RI-1:0];
  assign rx_sel  = SEL_W'(rx_idx);
  assign src_sel = imm ? SEL_IMM : SEL_W'(ry_idx);

  // The bits between RX and RY carry no control information (the
  // datapath takes the immediate from them directly).
  if (DATA_W > 4 + 2 * RI) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^ir_out[DATA_W-5-RI:RI];
  end

  // One-hot write enable for RX; an RX code beyond NUM_REGS-1 (only
  // possible with a non power-of-two register count) selects nothing.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rx_dec
    assign rx_onehot[gi] = (rx_idx == RI'(gi));
  end

  // ALU function for the three arithmetic/logic opcodes; 11 is never used.
  always_comb begin
    alu_code = 2'b00;
    case (op)
      OP_SUB:  alu_code = 2'b01;
      OP_AND:  alu_code = 2'b10;
      default: alu_code = 2'b00;
    endcase
  end

  // ------------------------------------------------------------------
  // State and timeout counter registers
  // ------------------------------------------------------------------

  // State register; reset may land at any time, including mid-handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath control decode from state + IR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = '0;
    rx_in   = '0;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    alu_op  = 2'b00;
    imm_hi  = 1'b0;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    halted  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end

      S_T0: begin
        // Latch the instruction; IR is only trusted from T1 on.
        ir_in   = 1'b1;
        state_d = S_T1;
      end

      S_T1: begin
        case (op)
          OP_MV: begin
            sel     = src_sel;
            rx_in   = rx_onehot;
            done    = 1'b1;
            state_d = S_IDLE;
          end
          OP_MVT: begin
            sel     = SEL_IMM;
            imm_hi  = 1'b1;
            rx_in   = rx_onehot;
            done    = 1'b1;
            state_d = S_IDLE;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel     = rx_sel;
            a_in    = 1'b1;
            state_d = S_T2;
          end
          OP_LD, OP_ST: begin
            sel     = src_sel;
            addr_in = 1'b1;
            state_d = S_T2;
          end
          OP_HALT: begin
            done    = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_T2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            sel     = src_sel;
            g_in    = 1'b1;
            alu_op  = alu_code;
            state_d = S_T3;
          end
          OP_LD: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          OP_ST: begin
            sel     = rx_sel;
            dout_in = 1'b1;
            cnt_d   = '0;
            state_d = S_MEM;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_wr  = (op == OP_ST);
        if (mem_ack) begin
          // An ack in the last permitted cycle still wins over the abort.
          state_d = S_T3;
        end else if (cnt_q == CNT_LAST) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            sel   = SEL_G;
            rx_in = rx_onehot;
          end
          OP_LD: begin
            sel   = SEL_DIN;
            rx_in = rx_onehot;
          end
          default: ;
        endcase
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_HALT: begin
        halted = 1'b1;
        if (!run) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm
// Random instruction streams against a cycle-list reference model for two
// configurations (16-bit/8 regs and 24-bit/16 regs), plus a reset taken in
// the middle of a memory handshake.
`timescale 1ns/1ps
module tb_proc_ctrl_fsm;

  localparam int TMO = 15;

  // Flag bit positions in the packed control vector.
  localparam logic [10:0] F_IR    = 11'h400;
  localparam logic [10:0] F_A     = 11'h200;
  localparam logic [10:0] F_G     = 11'h100;
  localparam logic [10:0] F_ADDR  = 11'h080;
  localparam logic [10:0] F_DOUT  = 11'h040;
  localparam logic [10:0] F_IMMHI = 11'h020;
  localparam logic [10:0] F_REQ   = 11'h010;
  localparam logic [10:0] F_WR    = 11'h008;
  localparam logic [10:0] F_DONE  = 11'h004;
  localparam logic [10:0] F_ERR   = 11'h002;
  localparam logic [10:0] F_HALT  = 11'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, run, mem_ack, which;
  logic [31:0] ir_w;
  logic        run_a, run_b;
  assign run_a = run & ~which;
  assign run_b = run & which;

  // 16-bit / 8-register instance
  logic [3:0]  sel_a;
  logic [7:0]  rx_a;
  logic [1:0]  alu_a;
  logic        ir_in_a, a_in_a, g_in_a, addr_in_a, dout_in_a;
  logic        imm_hi_a, req_a, wr_a, done_a, err_a, halted_a;

  // 24-bit / 16-register instance
  logic [4:0]  sel_b;
  logic [15:0] rx_b;
  logic [1:0]  alu_b;
  logic        ir_in_b, a_in_b, g_in_b, addr_in_b, dout_in_b;
  logic        imm_hi_b, req_b, wr_b, done_b, err_b, halted_b;

  proc_ctrl_fsm u_dut_a (
    .clk(clk), .reset_n(reset_n), .run(run_a), .ir_out(ir_w[15:0]),
    .mem_ack(mem_ack), .sel(sel_a), .rx_in(rx_a), .ir_in(ir_in_a),
    .a_in(a_in_a), .g_in(g_in_a), .addr_in(addr_in_a), .dout_in(dout_in_a),
    .alu_op(alu_a), .imm_hi(imm_hi_a), .mem_req(req_a), .mem_wr(wr_a),
    .done(done_a), .err(err_a), .halted(halted_a)
  );

  proc_ctrl_fsm #(.DATA_W(24), .NUM_REGS(16), .MEM_TIMEOUT(TMO)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .run(run_b), .ir_out(ir_w[23:0]),
    .mem_ack(mem_ack), .sel(sel_b), .rx_in(rx_b), .ir_in(ir_in_b),
    .a_in(a_in_b), .g_in(g_in_b), .addr_in(addr_in_b), .dout_in(dout_in_b),
    .alu_op(alu_b), .imm_hi(imm_hi_b), .mem_req(req_b), .mem_wr(wr_b),
    .done(done_b), .err(err_b), .halted(halted_b)
  );

  // Observation of whichever instance is under test.
  logic [31:0] o_sel, o_rx, o_alu, o_flags;
  always_comb begin
    if (!which) begin
      o_sel   = 32'(sel_a);
      o_rx    = 32'(rx_a);
      o_alu   = 32'(alu_a);
      o_flags = 32'({ir_in_a, a_in_a, g_in_a, addr_in_a, dout_in_a, imm_hi_a,
                     req_a, wr_a, done_a, err_a, halted_a});
    end else begin
      o_sel   = 32'(sel_b);
      o_rx    = 32'(rx_b);
      o_alu   = 32'(alu_b);
      o_flags = 32'({ir_in_b, a_in_b, g_in_b, addr_in_b, dout_in_b, imm_hi_b,
                     req_b, wr_b, done_b, err_b, halted_b});
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One expected clock cycle: the controls we must see and the inputs we apply.
  typedef struct {
    int          sel;
    int          rx;      // -1: no register write
    int          alu;
    logic [10:0] flags;
    logic        run;
    logic        ack;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic cyc_t mk(input int s, input int r, input int a, input logic [10:0] f);
    cyc_t c;
    c.sel   = s;
    c.rx    = r;
    c.alu   = a;
    c.flags = f;
    c.run   = 1'($urandom);   // ignored mid-instruction
    c.ack   = 1'($urandom);   // ignored outside the handshake
    return c;
  endfunction

  // Expand one instruction into its cycle list straight from the opcode rules.
  task automatic build(input logic [31:0] iw, input int dw, input int ri, input int n,
                       input int ack_at, input int hold);
    int   op, imm, rx, ry, src;
    cyc_t c;
    op  = int'((iw >> (dw - 3)) & 32'd7);
    imm = int'((iw >> (dw - 4)) & 32'd1);
    rx  = int'((iw >> (dw - 4 - ri)) & ((32'd1 << ri) - 32'd1));
    ry  = int'(iw & ((32'd1 << ri) - 32'd1));
    src = (imm != 0) ? n : ry;

    c = mk(0, -1, 0, 11'h0); c.run = 1'b1; exp_q.push_back(c);   // launch from IDLE
    exp_q.push_back(mk(0, -1, 0, F_IR));                          // fetch
    case (op)
      0: exp_q.push_back(mk(src, rx, 0, F_DONE));
      1: exp_q.push_back(mk(n, rx, 0, F_IMMHI | F_DONE));
      2, 3, 6: begin
        exp_q.push_back(mk(rx, -1, 0, F_A));
        exp_q.push_back(mk(src, -1, (op == 2) ? 0 : (op == 3) ? 1 : 2, F_G));
        exp_q.push_back(mk(n + 1, rx, 0, F_DONE));
      end
      4, 5: begin
        exp_q.push_back(mk(src, -1, 0, F_ADDR));
        if (op == 5) exp_q.push_back(mk(rx, -1, 0, F_DOUT));
        else         exp_q.push_back(mk(0, -1, 0, 11'h0));
        for (int k = 1; k <= TMO; k++) begin
          c = mk(0, -1, 0, F_REQ | ((op == 5) ? F_WR : 11'h0));
          c.ack = (k == ack_at);
          if (k == TMO && k != ack_at) c.flags = c.flags | F_DONE | F_ERR;
          exp_q.push_back(c);
          if (k == ack_at) break;
        end
        if (ack_at >= 1 && ack_at <= TMO) begin
          if (op == 4) exp_q.push_back(mk(n + 2, rx, 0, F_DONE));
          else         exp_q.push_back(mk(0, -1, 0, F_DONE));
        end
      end
      default: begin
        exp_q.push_back(mk(0, -1, 0, F_DONE));
        for (int h = 0; h < hold; h++) begin
          c = mk(0, -1, 0, F_HALT); c.run = 1'b1; exp_q.push_back(c);
        end
        c = mk(0, -1, 0, F_HALT); c.run = 1'b0; exp_q.push_back(c);
      end
    endcase
  endtask

  task automatic run_instr(input logic [31:0] iw, input int dw, input int ri, input int n,
                           input int ack_at, input int hold);
    cyc_t c;
    int   gap, idx, total;
    exp_q.delete();
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      c = mk(0, -1, 0, 11'h0); c.run = 1'b0; exp_q.push_back(c);
    end
    build(iw, dw, ri, n, ack_at, hold);
    total = exp_q.size();
    idx = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(negedge clk);
      if (idx == 0) ir_w = iw;   // previous instruction has fully retired here
      run     = c.run;
      mem_ack = c.ack;
      #1;
      check_val($sformatf("sel[%h c%0d]", iw, idx),   o_sel,   32'(c.sel));
      check_val($sformatf("rx_in[%h c%0d]", iw, idx), o_rx,
                (c.rx >= 0) ? (32'd1 << c.rx) : 32'd0);
      check_val($sformatf("alu_op[%h c%0d]", iw, idx), o_alu,  32'(c.alu));
      check_val($sformatf("ctl[%h c%0d]", iw, idx),   o_flags, 32'(c.flags));
      idx++;
    end
    $display("instr dw=%0d word=%h ack_at=%0d cycles=%0d", dw, iw, ack_at, total);
  endtask

  function automatic int pick_ack();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 0;
    if (r == 1) return TMO;
    return $urandom_range(1, TMO);
  endfunction

  task automatic expect_all_zero(input string tag);
    check_val({tag, "_sel"}, o_sel,   32'd0);
    check_val({tag, "_rx"},  o_rx,    32'd0);
    check_val({tag, "_alu"}, o_alu,   32'd0);
    check_val({tag, "_ctl"}, o_flags, 32'd0);
  endtask

  // LD abandoned in its second MEM cycle by an asynchronous reset.
  task automatic reset_mid_mem();
    which = 1'b0; mem_ack = 1'b0; run = 1'b0;
    @(negedge clk); ir_w = 32'h8603; run = 1'b1;   // IDLE
    repeat (5) @(negedge clk);                      // T0, T1, T2, MEM, MEM
    #1;
    check_val("pre_rst_req", 32'(req_a), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_val("rst_req_drop", 32'(req_a), 32'd0);
    expect_all_zero("rst_async");
    @(negedge clk); #1;
    expect_all_zero("rst_held");
    run = 1'b0;
    reset_n = 1'b1;
    $display("reset taken mid-MEM of LD 8603");
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; mem_ack = 1'b0; which = 1'b0; ir_w = 32'h0;
    #2;
    expect_all_zero("init_a");
    which = 1'b1; #1;
    expect_all_zero("init_b");
    which = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // ---- 16-bit, 8 registers ----
    run_instr(32'h1A05, 16, 3, 8, 0, 0);     // MV R5,#5
    run_instr(32'h2400, 16, 3, 8, 0, 0);     // MVT R2
    run_instr(32'h4201, 16, 3, 8, 0, 0);     // ADD R1,R1
    run_instr(32'h6201, 16, 3, 8, 0, 0);     // SUB R1,R1
    run_instr(32'hC201, 16, 3, 8, 0, 0);     // AND R1,R1
    run_instr(32'h8603, 16, 3, 8, 3, 0);     // LD R3,[R3], ack on 3rd MEM cycle
    run_instr(32'hA603, 16, 3, 8, 0, 0);     // ST, timeout
    run_instr(32'hA603, 16, 3, 8, TMO, 0);   // ST, ack on last allowed cycle
    run_instr(32'hE000, 16, 3, 8, 0, 3);     // HALT, run held 3 cycles
    reset_mid_mem();
    run_instr(32'h1A05, 16, 3, 8, 0, 0);     // release + run -> fetch next cycle
    for (int i = 0; i < 150; i++)
      run_instr($urandom & 32'hFFFF, 16, 3, 8, pick_ack(), $urandom_range(0, 3));

    // ---- 24-bit, 16 registers ----
    which = 1'b1;
    run_instr(32'h1D0007, 24, 4, 16, 0, 0);  // MV R13,#imm
    run_instr(32'h4F000E, 24, 4, 16, 0, 0);  // ADD R15,R14
    run_instr(32'h890002, 24, 4, 16, 2, 0);  // LD R9,[R2]
    run_instr(32'hA40005, 24, 4, 16, 0, 0);  // ST R4, timeout
    run_instr(32'hE00000, 24, 4, 16, 0, 1);  // HALT
    for (int i = 0; i < 100; i++)
      run_instr($urandom & 32'hFFFFFF, 24, 4, 16, pick_ack(), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
